program_loader: RTL and testbench

- Write-side counterpart of the byte-addressed instruction memory.
- Accepts a framed byte stream from a host link, e.g. a UART receiver, and writes the payload byte-by-byte into program memory.
- Holds the CPU in reset while loading, then releases it.
- Byte i of the payload lands at BASE_ADDR+i. Fetch assembles {RAM[a],RAM[a+1],RAM[a+2],RAM[a+3]}, so each instruction is sent MSB first.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/program_loader_if.sv | 23 ++
 rtl/loader_checksum.sv | 26 ++
 rtl/program_loader.sv | 115 +++++++++++
 tb/tb_program_loader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the program loader.
// Holds the loader state encoding, the length-header size and the checksum target.
// Imported by the loader top and its checksum sub-module.
package cpu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CHECK,
      DONE,
      ERROR
   } loader_state_t;

   // Number of big-endian length bytes at the head of a frame.
   localparam int LEN_BYTES = 4;

   // Payload sum plus trailer must land on this value for a good frame.
   localparam logic [7:0] CHK_OK = 8'h00;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and byte-write memory port of the program loader.
// Ports: in_valid/in_data/in_ready (stream handshake), mem_we/mem_addr/mem_wdata (memory write).
// slave modport is the loader side; master modport is the host link plus memory side.
interface program_loader_if;

   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/loader_checksum.sv
// 8-bit running sum of payload bytes with synchronous clear and enable.
// Ports: clk, reset, clr, en, din (byte to add / trailer to test), sum, ok.
// ok compares sum + din against the good-frame target, so it is valid on the trailer byte.
module loader_checksum
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] sum,
   output logic       ok
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         sum <= 8'h00;
      end else if (en) begin
         sum <= sum + din;
      end
   end

   assign ok = (8'(sum + din) == CHK_OK);

endmodule

// File: rtl/program_loader.sv
// Loads a framed byte stream (LEN[4] | DATA[N] | CHECK) into program memory.
// Ports: clk, reset, start, bus (stream + memory write), cpu_hold, done, error, byte_count.
// One byte per cycle when in_valid is held; writes appear one cycle after the byte is accepted.
module program_loader
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   program_loader_if.slave   bus,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [31:0]       byte_count
);

   loader_state_t state, state_nxt;

   logic [31:0] len;
   logic [1:0]  len_idx;
   logic        ready;
   logic        accept;
   logic        load_go;
   logic        data_wr;
   logic        chk_ok;
   logic [31:0] len_full;

   assign ready    = (state == LEN) || (state == DATA) || (state == CHECK);
   assign accept   = bus.in_valid && ready;
   // A new load may only begin from a resting state; start is ignored mid-frame.
   assign load_go  = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
   assign data_wr  = accept && (state == DATA);
   // Length including the byte being accepted now, used to decide on the 4th byte.
   assign len_full = {len[23:0], bus.in_data};

   assign bus.in_ready = ready;
   assign done         = (state == DONE);
   assign error        = (state == ERROR);
   // ERROR keeps the CPU held so a partial image is never executed.
   assign cpu_hold     = ready || (state == ERROR);

   loader_checksum u_checksum (
      .clk   (clk),
      .reset (reset),
      .clr   (load_go),
      .en    (data_wr),
      .din   (bus.in_data),
      .sum   (),
      .ok    (chk_ok)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERROR: begin
            if (start) state_nxt = LEN;
         end
         LEN: begin
            if (accept && (len_idx == 2'(LEN_BYTES - 1))) begin
               if (len_full > 32'(MEM_BYTES)) state_nxt = ERROR;
               else if (len_full == 32'd0)    state_nxt = CHECK;
               else                           state_nxt = DATA;
            end
         end
         DATA: begin
            // byte_count already equals the index of the byte being accepted.
            if (accept && ((byte_count + 32'd1) == len)) state_nxt = CHECK;
         end
         CHECK: begin
            if (accept) state_nxt = chk_ok ? DONE : ERROR;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len        <= 32'd0;
         len_idx    <= 2'd0;
         byte_count <= 32'd0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= 32'd0;
         bus.mem_wdata <= 8'h00;
      end else begin
         bus.mem_we <= data_wr;
         if (load_go) begin
            len        <= 32'd0;
            len_idx    <= 2'd0;
            byte_count <= 32'd0;
         end
         if (accept && (state == LEN)) begin
            len     <= len_full;
            len_idx <= len_idx + 2'd1;
         end
         if (data_wr) begin
            bus.mem_addr  <= BASE_ADDR + byte_count;
            bus.mem_wdata <= bus.in_data;
            byte_count    <= byte_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames with hand-computed checksums, flow-control gaps,
// oversize / zero-length / full-size boundaries and reset mid-load.
// Ports: none; drives the loader through program_loader_if and captures memory writes.
module tb_program_loader;

   logic        clk;
   logic        reset;
   logic        start;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [31:0] byte_count;

   program_loader_if bus();

   program_loader #(.MEM_BYTES(256), .BASE_ADDR(32'h0000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bus        (bus),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .byte_count (byte_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Write capture: memory image plus address and cycle of every write.
   logic [7:0]  mem_img [0:255];
   logic [31:0] wr_addr [0:511];
   int          wr_cyc  [0:511];
   int          wr_cnt = 0;

   always @(negedge clk) begin
      if (bus.mem_we) begin
         mem_img[bus.mem_addr[7:0]] = bus.mem_wdata;
         wr_addr[wr_cnt] = bus.mem_addr;
         wr_cyc[wr_cnt]  = cyc;
         wr_cnt = wr_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present one byte and return at the negedge after it was accepted.
   task automatic send(input logic [7:0] b);
      int t;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      t = 0;
      while (!bus.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] q[$]);
      foreach (q[i]) send(q[i]);
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   logic [7:0] frame [$];
   logic [31:0] fetch;
   int w0;
   int gaps [0:8] = '{1, 0, 2, 1, 3, 1, 2, 0, 1};

   initial begin
      reset = 1'b1;
      start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      check("rst_in_ready",   {31'd0, bus.in_ready}, 32'd0);
      check("rst_mem_we",     {31'd0, bus.mem_we},   32'd0);
      check("rst_mem_addr",   bus.mem_addr,          32'd0);
      check("rst_mem_wdata",  {24'd0, bus.mem_wdata}, 32'd0);
      check("rst_cpu_hold",   {31'd0, cpu_hold},     32'd0);
      check("rst_done",       {31'd0, done},         32'd0);
      check("rst_error",      {31'd0, error},        32'd0);
      check("rst_byte_count", byte_count,            32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Nominal: payload 00 A0 00 93 sums to 0x33, so the good trailer is 0xCD.
      w0 = wr_cnt;
      pulse_start();
      check("len_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      check("len_in_ready", {31'd0, bus.in_ready}, 32'd1);
      frame = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'hA0, 8'h00, 8'h93, 8'hCD};
      send_frame(frame);
      settle();
      check("nom_writes",     wr_cnt - w0, 32'd4);
      check("nom_addr0",      wr_addr[w0],   32'd0);
      check("nom_addr3",      wr_addr[w0+3], 32'd3);
      check("nom_b2b",        wr_cyc[w0+3] - wr_cyc[w0], 32'd3);
      check("nom_done",       {31'd0, done},     32'd1);
      check("nom_error",      {31'd0, error},    32'd0);
      check("nom_cpu_hold",   {31'd0, cpu_hold}, 32'd0);
      check("nom_byte_count", byte_count,        32'd4);
      fetch = {mem_img[0], mem_img[1], mem_img[2], mem_img[3]};
      check("nom_fetch",      fetch,             32'h00A00093);

      // in_valid while not ready consumes nothing.
      w0 = wr_cnt;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      settle();
      check("idle_valid_writes", wr_cnt - w0, 32'd0);
      check("idle_valid_count",  byte_count,  32'd4);
      check("idle_valid_done",   {31'd0, done}, 32'd1);

      // Bad trailer: writes still happen, then ERROR with the CPU held.
      w0 = wr_cnt;
      pulse_start();
      check("restart_done_clr", {31'd0, done}, 32'd0);
      frame = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'hA0, 8'h00, 8'h93, 8'hC1};
      send_frame(frame);
      settle();
      check("bad_writes",   wr_cnt - w0,       32'd4);
      check("bad_error",    {31'd0, error},    32'd1);
      check("bad_done",     {31'd0, done},     32'd0);
      check("bad_cpu_hold", {31'd0, cpu_hold}, 32'd1);

      // Oversize length 257: ERROR straight after the 4th length byte.
      w0 = wr_cnt;
      pulse_start();
      frame = '{8'h00, 8'h00, 8'h01, 8'h01};
      send_frame(frame);
      check("over_error",    {31'd0, error},        32'd1);
      check("over_in_ready", {31'd0, bus.in_ready}, 32'd0);
      settle();
      check("over_writes",   wr_cnt - w0,           32'd0);
      check("over_count",    byte_count,            32'd0);

      // Zero length with good trailer.
      w0 = wr_cnt;
      pulse_start();
      frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(frame);
      settle();
      check("zero_done",   {31'd0, done}, 32'd1);
      check("zero_writes", wr_cnt - w0,   32'd0);

      // Zero length with bad trailer.
      pulse_start();
      frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      send_frame(frame);
      settle();
      check("zero_bad_error", {31'd0, error}, 32'd1);

      // Full-size 256-byte payload of bytes 0..255: sum 0x7F80 -> 0x80, trailer 0x80.
      w0 = wr_cnt;
      pulse_start();
      frame = '{8'h00, 8'h00, 8'h01, 8'h00};
      for (int i = 0; i < 256; i++) frame.push_back(8'(i));
      frame.push_back(8'h80);
      send_frame(frame);
      settle();
      check("full_done",    {31'd0, done}, 32'd1);
      check("full_writes",  wr_cnt - w0,   32'd256);
      check("full_last",    wr_addr[w0+255], 32'd255);
      check("full_count",   byte_count,    32'd256);
      check("full_byte200", {24'd0, mem_img[200]}, 32'd200);

      // Flow control: idle gaps between bytes, start pulsed during a DATA gap.
      w0 = wr_cnt;
      pulse_start();
      frame = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'hA0, 8'h00, 8'h93, 8'hCD};
      foreach (frame[i]) begin
         bus.in_valid = 1'b0;
         for (int g = 0; g < gaps[i]; g++) begin
            start = (i == 6 && g == 0);
            @(negedge clk);
            start = 1'b0;
         end
         send(frame[i]);
      end
      bus.in_valid = 1'b0;
      settle();
      check("flow_writes", wr_cnt - w0, 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("flow_addr%0d", i), wr_addr[w0+i], 32'(i));
      check("flow_done",  {31'd0, done}, 32'd1);
      fetch = {mem_img[0], mem_img[1], mem_img[2], mem_img[3]};
      check("flow_fetch", fetch, 32'h00A00093);

      // Reset after two payload bytes aborts to reset values.
      pulse_start();
      frame = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22};
      send_frame(frame);
      reset = 1'b1;
      settle();
      check("mid_rst_cpu_hold", {31'd0, cpu_hold},     32'd0);
      check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("mid_rst_mem_we",   {31'd0, bus.mem_we},   32'd0);
      check("mid_rst_addr",     bus.mem_addr,          32'd0);
      check("mid_rst_count",    byte_count,            32'd0);
      check("mid_rst_flags",    {30'd0, done, error},  32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Reload from address 0: payload 11 22 33 44 sums to 0xAA, trailer 0x56.
      w0 = wr_cnt;
      pulse_start();
      frame = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56};
      send_frame(frame);
      settle();
      check("reload_done",  {31'd0, done}, 32'd1);
      check("reload_addr0", wr_addr[w0],   32'd0);
      fetch = {mem_img[0], mem_img[1], mem_img[2], mem_img[3]};
      check("reload_fetch", fetch, 32'h11223344);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
